wb_rr_arbiter: RTL
==================

# wb_rr_arbiter

Round-robin Wishbone arbiter sharing one slave port (on-chip RAM or a crossbar slave leg) between several bus masters: the debug module, the core's MEM stage and the core's IF stage. Arbitration takes one registered cycle. A grant is held for the whole bus cycle, for as long as the granted master keeps `cyc` high. The block sits between the masters and the slave in the SoC wrapper, and the optional bus watchdog keeps a dead slave from locking up the core.

## Interface
Parameters:
- `N_MASTER`, 3, number of requesters, 2..8; index 0 is the debug master by convention.
- `AW`, 32, address width.
- `DW`, 32, data width; select width is `DW/8`.
- `TIMEOUT`, 255, watchdog limit in cycles; used only when `WB_ARB_TIMEOUT_EN` is defined; range 1..65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `m_cyc_i` in N_MASTER: per-master cycle request.
- `m_stb_i` in N_MASTER: per-master strobe.
- `m_we_i` in N_MASTER: per-master write enable.
- `m_sel_i` in N_MASTER*DW/8: byte selects, master i at slice [i*DW/8 +: DW/8].
- `m_adr_i` in N_MASTER*AW: addresses, same slicing.
- `m_dat_i` in N_MASTER*DW: write data, same slicing.
- `m_dat_o` out DW: slave read data, broadcast to all masters.
- `m_ack_o` out N_MASTER: ack, routed to the granted master only.
- `m_err_o` out N_MASTER: error, routed to the granted master only.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: slave-side controls.
- `s_sel_o` out DW/8: slave byte selects.
- `s_adr_o` out AW: slave address.
- `s_dat_o` out DW: slave write data.
- `s_dat_i` in DW: slave read data.
- `s_ack_i`, `s_err_i` in 1: slave responses.
- `grant_o` out N_MASTER: one-hot current grant, all-zero when idle.

## Operation
- FSM with two states, IDLE and BUSY. Registers: `state`, `grant` (one-hot), `last` (index of the most recent grant).
- IDLE: if any `m_cyc_i` is high, grant the first requester found by searching `last+1, last+2, …` modulo `N_MASTER`, wrapping around. Load `grant`, set `last` to that index, go to BUSY. With no requests, stay in IDLE.
- BUSY:
  - `s_*` outputs are a combinational mux of the granted master's signals.
  - `m_ack_o[g] = s_ack_i` and `m_err_o[g] = s_err_i`; all other bits of `m_ack_o`/`m_err_o` are 0.
  - When the granted master drops `m_cyc_i[g]`, clear `grant` and return to IDLE. That return cycle is a 1-cycle bubble and no new grant is issued in it.
- IDLE outputs: `s_cyc_o`/`s_stb_o`/`s_we_o` are 0, `s_sel_o`/`s_adr_o`/`s_dat_o` are 0, `m_ack_o`/`m_err_o` are 0.
- `m_dat_o` always equals `s_dat_i`.
- A master that drops `cyc` before it is granted loses its turn without side effects.
- A slave `ack` or `err` arriving while in IDLE is ignored.
- Reset, including mid-transfer: `state` goes to IDLE, `grant` to 0, `last` to `N_MASTER-1`, so master 0 wins the first arbitration. All outputs take their IDLE values immediately (asynchronous reset).

## Timing
- Arbitration latency: a request seen in cycle n gives `grant_o` and the slave signals valid in cycle n+1.
- Slave response latency passes straight through; `ack`/`err` paths are combinational.
- Back-to-back requests from different masters: minimum 2 cycles between one master's `cyc` falling and the next master's `s_cyc_o` rising.
- No grant change is allowed while `m_cyc_i[g]` is high; this preserves locked read-modify-write sequences.
- Fairness: each requester that holds `cyc` continuously is granted within `N_MASTER-1` other grants.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on every grant and on every `s_ack_i`/`s_err_i`.
  - It increments each BUSY cycle in which `s_stb_o` is high and neither response is present.
  - When the count equals `TIMEOUT`, that cycle: `m_err_o[g]=1`, `s_stb_o` forced to 0, counter cleared. The grant stays held until the master drops `cyc`.
- `WB_ARB_TIMEOUT_EN` undefined: no counter, no injected errors; the arbiter waits forever on the slave.

## Test plan
- Reset, then master 1 single read, slave acks 2 cycles after `stb` with data 0xDEADBEEF → `grant_o`=3'b010 one cycle after `cyc`; `m_ack_o`=3'b010 and `m_dat_o`=0xDEADBEEF; back to IDLE after `cyc` drops.
- All 3 masters hold `cyc` continuously, each completing 4 transfers per grant → grant order 0,1,2,0,1,2 with a 1-cycle idle bubble between grants.
- Master 2 granted, master 0 raises `cyc` mid-burst → master 2 keeps the grant for all 8 beats; master 0 is granted 2 cycles after master 2 drops `cyc`.
- Assert `rstn_i`=0 mid-write from master 1 → `s_cyc_o`, `s_stb_o`, `grant_o` are 0 asynchronously; after release with all masters requesting, master 0 is granted first.
- Spurious `s_ack_i` pulse while IDLE → `m_ack_o` stays 3'b000.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT`=16, slave never acks → `m_err_o[g]` pulses 16 cycles after `stb` rises; `s_stb_o` is 0 in that cycle; the grant is released when the master drops `cyc`.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters onto one slave port.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int N_MASTER = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rstn_i,
  input  logic [N_MASTER-1:0]      m_cyc_i,
  input  logic [N_MASTER-1:0]      m_stb_i,
  input  logic [N_MASTER-1:0]      m_we_i,
  input  logic [N_MASTER*DW/8-1:0] m_sel_i,
  input  logic [N_MASTER*AW-1:0]   m_adr_i,
  input  logic [N_MASTER*DW-1:0]   m_dat_i,
  output logic [DW-1:0]            m_dat_o,
  output logic [N_MASTER-1:0]      m_ack_o,
  output logic [N_MASTER-1:0]      m_err_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [DW/8-1:0]          s_sel_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  input  logic [DW-1:0]            s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [N_MASTER-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(N_MASTER);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       pick;
  logic                found;
  logic                busy;
  logic                to_hit;
  int                  j;

  // Search starts just after the previous winner and wraps.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    j     = 0;
    for (int k = 1; k <= N_MASTER; k++) begin
      j = int'(last_q) + k;
      if (j >= N_MASTER) j = j - N_MASTER;
      if (!found && m_cyc_i[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = N_MASTER'(1) << pick;
          last_d  = pick;
        end
      end
      BUSY: begin
        if (!m_cyc_i[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_MASTER - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign busy = (state_q == BUSY);

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;

  assign to_hit = busy && (cnt_q == 16'(TIMEOUT));

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (!busy || s_ack_i || s_err_i || to_hit) begin
      cnt_q <= '0;
    end else if (s_stb_o) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // last_q names the owner while BUSY, so it doubles as the mux select.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      s_cyc_o = m_cyc_i[last_q];
      s_stb_o = m_stb_i[last_q] & ~to_hit;
      s_we_o  = m_we_i[last_q];
      s_sel_o = m_sel_i[last_q*SW +: SW];
      s_adr_o = m_adr_i[last_q*AW +: AW];
      s_dat_o = m_dat_i[last_q*DW +: DW];
      m_ack_o = s_ack_i ? grant_q : '0;
      m_err_o = (s_err_i | to_hit) ? grant_q : '0;
    end
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

endmodule
